// File: rtl/m_div_controller.sv
// Sequencing controller for the M-extension iterative restoring divider.
// Drives datapath mux selects, applies RISC-V sign fix-up and special cases, registers result.
module m_div_controller #(
  parameter int unsigned ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        kill,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] R,
  input  logic [31:0] Z,
  output logic [1:0]  mux_R,
  output logic [1:0]  mux_D,
  output logic [1:0]  mux_Z,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] SelKeep   = 2'd0;
  localparam logic [1:0] SelRA     = 2'd1;
  localparam logic [1:0] SelRANeg  = 2'd2;
  localparam logic [1:0] SelRSub   = 2'd3;
  localparam logic [1:0] SelDB     = 2'd1;
  localparam logic [1:0] SelDBNeg  = 2'd2;
  localparam logic [1:0] SelDShr   = 2'd3;
  localparam logic [1:0] SelZZero  = 2'd1;
  localparam logic [1:0] SelZShl   = 2'd2;
  localparam logic [4:0] LastCnt   = 5'(ITERATIONS - 1);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [4:0]  r_cnt, w_cnt_d;
  logic        r_busy, w_busy_d;
  logic [31:0] r_result, w_result_d;
  logic        r_is_rem, w_is_rem_d;
  logic        r_neg_q, w_neg_q_d;
  logic        r_neg_r, w_neg_r_d;

  logic        w_is_signed;
  logic        w_div_zero;
  logic        w_overflow;

  assign w_is_signed = ~op[0];
  assign w_div_zero  = (rs2 == 32'd0);
  assign w_overflow  = w_is_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_busy_d   = 1'b0;
    w_result_d = r_result;
    w_is_rem_d = r_is_rem;
    w_neg_q_d  = r_neg_q;
    w_neg_r_d  = r_neg_r;
    mux_R      = SelKeep;
    mux_D      = SelKeep;
    mux_Z      = SelKeep;

    unique case (r_state)
      StIdle: begin
        if (start && !kill) begin
          w_is_rem_d = op[1];
          w_neg_q_d  = w_is_signed & (rs1[31] ^ rs2[31]);
          w_neg_r_d  = w_is_signed & rs1[31];
          if (w_div_zero) begin
            w_result_d = op[1] ? rs1 : 32'hFFFF_FFFF;
            w_state_d  = StDone;
          end else if (w_overflow) begin
            w_result_d = op[1] ? 32'd0 : 32'h8000_0000;
            w_state_d  = StDone;
          end else begin
            // Operands load as magnitudes; sign is restored in FIX.
            mux_R     = (w_is_signed && rs1[31]) ? SelRANeg : SelRA;
            mux_D     = (w_is_signed && rs2[31]) ? SelDBNeg : SelDB;
            mux_Z     = SelZZero;
            w_cnt_d   = 5'd0;
            w_busy_d  = 1'b1;
            w_state_d = StIter;
          end
        end
      end
      StIter: begin
        if (kill) begin
          w_state_d = StIdle;
        end else begin
          mux_R    = SelRSub;
          mux_D    = SelDShr;
          mux_Z    = SelZShl;
          w_cnt_d  = r_cnt + 5'd1;
          w_busy_d = 1'b1;
          if (r_cnt == LastCnt) begin
            w_state_d = StFix;
          end
        end
      end
      StFix: begin
        if (kill) begin
          w_state_d = StIdle;
        end else begin
          if (r_is_rem) begin
            w_result_d = r_neg_r ? (32'd0 - R) : R;
          end else begin
            w_result_d = r_neg_q ? (32'd0 - Z) : Z;
          end
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= StIdle;
      r_cnt    <= 5'd0;
      r_busy   <= 1'b0;
      r_result <= 32'd0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_busy   <= w_busy_d;
      r_result <= w_result_d;
      r_is_rem <= w_is_rem_d;
      r_neg_q  <= w_neg_q_d;
      r_neg_r  <= w_neg_r_d;
    end
  end

  assign busy   = r_busy;
  assign done   = (r_state == StDone);
  assign result = r_result;

endmodule

// File: doc/m_div_controller.md
# m_div_controller

Sequencing controller for the M-extension iterative divider datapath (remainder R, divisor D and quotient Z registers with mux-selected next-state logic). It accepts DIV/DIVU/REM/REMU requests and drives the datapath mux selects through a 32-iteration restoring division. It applies RISC-V sign correction and handles divide-by-zero and signed overflow without iterating. It returns a registered 32-bit result with a one-cycle done pulse.

## Interface
- ITERATIONS, 32: division steps per operation; fixed for RV32.
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  request strobe; accepted only when busy=0.
- kill  in  1  synchronous abort (pipeline flush); no done is produced.
- op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- rs1  in  32  dividend; sampled only in the accept cycle.
- rs2  in  32  divisor; sampled only in the accept cycle.
- R  in  32  datapath remainder register.
- Z  in  32  datapath quotient register.
- mux_R  out  2  datapath remainder select: 0 KEEP, 1 A, 2 A_NEG, 3 SUB_KEEP.
- mux_D  out  2  datapath divisor select: 0 KEEP, 1 B, 2 B_NEG, 3 SHR.
- mux_Z  out  2  datapath quotient select: 0 KEEP, 1 ZERO, 2 SHL_ADD.
- busy  out  1  operation in flight; high from the cycle after accept until done.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- result  out  32  quotient or remainder; holds its value until the next done.

## Operation
- FSM states: IDLE, ITER, FIX, DONE. A 5-bit iteration counter counts 0..ITERATIONS-1.
- Accept condition: start=1, state IDLE, kill=0. In the accept cycle the controller latches:
  - is_signed = ~op[0]
  - is_rem = op[1]
  - neg_q = is_signed & (rs1[31] ^ rs2[31])
  - neg_r = is_signed & rs1[31]
- Special cases are checked first, in the accept cycle:
  - rs2 == 0: result = is_rem ? rs1 : 32'hFFFF_FFFF.
  - Signed overflow (is_signed, rs1 = 32'h8000_0000, rs2 = 32'hFFFF_FFFF): result = is_rem ? 0 : 32'h8000_0000.
  - On a special case: result is registered, next state is DONE, all mux selects stay KEEP.
- Normal accept, load is driven combinationally in the accept cycle:
  - mux_R = (is_signed & rs1[31]) ? A_NEG : A
  - mux_D = (is_signed & rs2[31]) ? B_NEG : B
  - mux_Z = ZERO
  - Next state ITER, counter = 0.
- ITER: mux_R = SUB_KEEP, mux_D = SHR, mux_Z = SHL_ADD. The counter increments each cycle. After the count of ITERATIONS-1, next state is FIX.
- FIX: all selects KEEP. Register result:
  - REM/REMU: neg_r ? -R : R
  - DIV/DIVU: neg_q ? -Z : Z
  - Negation is two's complement modulo 2^32. Next state DONE.
- DONE: done = 1, busy = 0, selects KEEP. Next state IDLE.
- In IDLE, DONE and FIX all selects are KEEP. Selects are non-KEEP only in the accept cycle and in ITER.
- A start arriving while busy=1 or in DONE is ignored. It is not queued.
- kill in ITER or FIX: next state IDLE, selects KEEP in the kill cycle, no done, result unchanged.
- kill in the accept cycle: the start is not accepted.
- kill in DONE: no effect; done still pulses.

## Timing
- Reset values:
  - state IDLE, counter 0
  - busy 0, done 0, result 0
  - mux_R / mux_D / mux_Z = 0 (KEEP)
  - latched flags 0
- Latency, normal operation (accept in cycle T):
  - ITER occupies T+1..T+32.
  - FIX occupies T+33.
  - done = 1 in T+34.
  - Next accept is possible in T+35.
- Latency, special case: done = 1 in T+1.
- busy is registered: high T+1 through the cycle before done, low in the done cycle.
- resetn assertion mid-operation forces all reset values immediately (asynchronous). No done is produced for the aborted operation.
- The datapath registers are owned by the datapath block. The controller never relies on their value outside ITER/FIX after a kill.

## Test plan
- DIVU rs1=100, rs2=7 accepted at T -> result=14 with done at T+34. REMU on the same operands -> result=2; busy high T+1..T+33.
- DIV rs1=-7 (32'hFFFF_FFF9), rs2=2 -> result=32'hFFFF_FFFD (-3). REM on the same operands -> result=32'hFFFF_FFFF (-1). DIV rs1=7, rs2=-2 -> result=-3.
- Divide by zero: DIV 5/0 -> 32'hFFFF_FFFF, and REMU 5/0 -> 5. Both with done at T+1 and selects KEEP throughout.
- Overflow: DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000; REM on the same operands -> 0. Both with done at T+1.
- Second start at T+5 during an operation is ignored; the first result is unchanged at T+34. A back-to-back start at T+35 is accepted.
- Two aborts:
  - kill at iteration 10 -> IDLE next cycle, no done, result retains its prior value, and a new DIVU 9/3 -> 3.
  - resetn low at iteration 20 -> all outputs 0 immediately.
